pipelined_addsub: RTL and testbench

- Parametrised, pipelined successor to the fixed 16-bit ripple adder.
- Adds or subtracts two WIDTH-bit operands. The carry chain is split across STAGES register slices.
- Uses a valid/ready handshake on both sides, so it can sit inside the ALU datapath with back-pressure.
- Produces sum, carry-out, signed overflow and zero flags.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/addsub_slice.sv | 36 +++
 rtl/pipelined_addsub.sv | 183 ++++++++++++++++++
 tb/tb_pipelined_addsub.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU datapath types and constants.
// Provides the add/subtract mode encoding, the result flag bundle and the saturation pattern helper.
package alu_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  typedef struct packed {
    logic c_out;
    logic overflow;
    logic zero;
  } flags_t;

  // Signed max (neg = 0) or signed min (neg = 1) for a w-bit word, right-aligned in 64 bits.
  function automatic logic [63:0] sat_pattern(input int unsigned w, input logic neg);
    logic [63:0] msb;
    msb = 64'd1 << (w - 1);
    return neg ? msb : (msb - 64'd1);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: one C-bit chunk of the skewed carry chain.
// Registers its sum chunk, carry-out and valid bit; everything holds while en is low.
module addsub_slice #(
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         vld_in,
  input  logic         cy_in,
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  output logic [C-1:0] sum_nxt,
  output logic [C-1:0] sum_p,
  output logic         cy_p,
  output logic         vld_p
);

  logic [C:0] tot;

  assign tot     = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, cy_in};
  assign sum_nxt = tot[C-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= 1'b0;
      cy_p  <= 1'b0;
      sum_p <= '0;
    end else if (en) begin
      vld_p <= vld_in;
      cy_p  <= tot[C];
      sum_p <= sum_nxt;
    end
  end

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: valid/ready add/subtract with the carry chain split over STAGES slices.
// Define SATURATE_EN to add the per-beat sat input that clamps signed overflow to max/min.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
`ifdef SATURATE_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int C = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic [C-1:0]     a_ck   [STAGES];
  logic [C-1:0]     b_ck   [STAGES];
  logic [C-1:0]     s_nxt  [STAGES];
  logic [C-1:0]     s_p    [STAGES];
  logic [C-1:0]     res_ck [STAGES];
  logic             cy_ck  [STAGES];
  logic             vld_ck [STAGES];
  logic             cy_p   [STAGES];
  logic             vld_p  [STAGES];
  logic             zin    [STAGES];
  logic             ovf_nxt, zero_nxt, clamp_nxt;
  logic             ovf_p, zero_p;
  logic [WIDTH-1:0] raw;
  flags_t           flg;

  assign out_valid = vld_p[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign b_eff     = (sub == SUB) ? ~b : b;
  assign c0        = (sub == SUB) ? ~c_in : c_in;

  // Stage 0 takes live inputs; slice k uses the carry registered by slice k-1.
  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    if (k == 0) begin : g_head
      assign a_ck[0]   = a[C-1:0];
      assign b_ck[0]   = b_eff[C-1:0];
      assign cy_ck[0]  = c0;
      assign vld_ck[0] = in_valid;
      assign zin[0]    = 1'b1;
    end else begin : g_tail
      assign cy_ck[k]  = cy_p[k-1];
      assign vld_ck[k] = vld_p[k-1];
    end

    addsub_slice #(.C(C)) u_slice (
      .clk     (clk),
      .rst     (rst),
      .en      (adv),
      .vld_in  (vld_ck[k]),
      .cy_in   (cy_ck[k]),
      .a       (a_ck[k]),
      .b       (b_ck[k]),
      .sum_nxt (s_nxt[k]),
      .sum_p   (s_p[k]),
      .cy_p    (cy_p[k]),
      .vld_p   (vld_p[k])
    );
  end

  // Operand chunk k waits k cycles; the lower-chunks-zero bit rides alongside it.
  for (genvar k = 1; k < STAGES; k++) begin : g_skew
    logic [C-1:0] a_dl [k];
    logic [C-1:0] b_dl [k];
    logic         z_r;

    always_ff @(posedge clk) begin
      if (adv) begin
        a_dl[0] <= a[k*C +: C];
        b_dl[0] <= b_eff[k*C +: C];
        for (int i = 1; i < k; i++) begin
          a_dl[i] <= a_dl[i-1];
          b_dl[i] <= b_dl[i-1];
        end
        z_r <= zin[k-1] && (s_nxt[k-1] == '0);
      end
    end

    assign a_ck[k] = a_dl[k-1];
    assign b_ck[k] = b_dl[k-1];
    assign zin[k]  = z_r;
  end

  // Finished lower chunks are delayed until the top slice catches up.
  for (genvar j = 0; j < STAGES - 1; j++) begin : g_lo
    localparam int D = STAGES - 1 - j;
    logic [C-1:0] s_dl [D];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < D; i++) s_dl[i] <= '0;
      end else if (adv) begin
        s_dl[0] <= s_p[j];
        for (int i = 1; i < D; i++) s_dl[i] <= s_dl[i-1];
      end
    end

    assign res_ck[j] = s_dl[D-1];
  end

  assign res_ck[STAGES-1] = s_p[STAGES-1];

  always_comb begin
    raw = '0;
    for (int j = 0; j < STAGES; j++) raw[j*C +: C] = res_ck[j];
  end

  assign ovf_nxt = (a_ck[STAGES-1][C-1] == b_ck[STAGES-1][C-1]) &&
                   (s_nxt[STAGES-1][C-1] != a_ck[STAGES-1][C-1]);

`ifdef SATURATE_EN
  logic        sat_f, clamp_p, neg_p;
  logic [63:0] sat_full;

  if (STAGES > 1) begin : g_sat
    logic sat_dl [STAGES-1];
    always_ff @(posedge clk) begin
      if (adv) begin
        sat_dl[0] <= sat;
        for (int i = 1; i < STAGES - 1; i++) sat_dl[i] <= sat_dl[i-1];
      end
    end
    assign sat_f = sat_dl[STAGES-2];
  end else begin : g_sat_direct
    assign sat_f = sat;
  end

  assign clamp_nxt = sat_f && ovf_nxt;
  assign sat_full  = sat_pattern(WIDTH, neg_p);
  assign sum       = clamp_p ? sat_full[WIDTH-1:0] : raw;
`else
  assign clamp_nxt = 1'b0;
  assign sum       = raw;
`endif

  assign zero_nxt = zin[STAGES-1] && (s_nxt[STAGES-1] == '0) && !clamp_nxt;

  // Flags are captured with the final sum chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_p  <= 1'b0;
      zero_p <= 1'b0;
`ifdef SATURATE_EN
      clamp_p <= 1'b0;
      neg_p   <= 1'b0;
`endif
    end else if (adv) begin
      ovf_p  <= ovf_nxt;
      zero_p <= zero_nxt;
`ifdef SATURATE_EN
      clamp_p <= clamp_nxt;
      neg_p   <= a_ck[STAGES-1][C-1];
`endif
    end
  end

  assign flg      = {cy_p[STAGES-1], ovf_p, zero_p};
  assign c_out    = flg.c_out;
  assign overflow = flg.overflow;
  assign zero     = flg.zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed corner beats plus randomized traffic with back-pressure,
// checked against an arithmetic reference and a slot-level latency model.
module tb_pipelined_addsub;
  import alu_pkg::*;

  localparam int WIDTH  = 16;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, c_in, sub, out_valid, out_ready;
  logic             c_out, overflow, zero;
  logic [WIDTH-1:0] a, b, sum;
`ifdef SATURATE_EN
  logic             sat;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic             mv [STAGES];
  logic [WIDTH+2:0] mr [STAGES];
  logic             chk_rst;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
`ifdef SATURATE_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; packed as {c_out, overflow, zero, sum}.
  function automatic logic [WIDTH+2:0] ref_calc(input logic [WIDTH-1:0] ia, ib,
                                                 input logic ic, isb, isat);
    longint ua, ub, sa, sb, s_u, s_s, smax, smin;
    logic co, ov;
    logic [WIDTH-1:0] r;
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    smin = -(longint'(1) << (WIDTH - 1));
    ua = longint'(ia);
    ub = longint'(ib);
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    if (isb == SUB) begin
      s_u = ua - ub - longint'(ic);
      s_s = sa - sb - longint'(ic);
      co  = (s_u >= 0);
    end else begin
      s_u = ua + ub + longint'(ic);
      s_s = sa + sb + longint'(ic);
      co  = (s_u >= (longint'(1) << WIDTH));
    end
    ov = (s_s > smax) || (s_s < smin);
    r  = s_u[WIDTH-1:0];
    if (isat && ov) r = (s_s > 0) ? smax[WIDTH-1:0] : smin[WIDTH-1:0];
    return {co, ov, (r == '0), r};
  endfunction

  task automatic step(input logic r, iv, input logic [WIDTH-1:0] ia, ib,
                      input logic ic, isb, isat, ord);
    logic adv_m, sat_m;
    @(negedge clk);
    rst = r; in_valid = iv; a = ia; b = ib; c_in = ic; sub = isb; out_ready = ord;
`ifdef SATURATE_EN
    sat   = isat;
    sat_m = isat;
`else
    sat_m = 1'b0;
    if (isat) sat_m = 1'b0;
`endif
    #1;
    adv_m = !mv[STAGES-1] || ord;
    if (!r) begin
      check_val("out_valid", 32'(out_valid), 32'(mv[STAGES-1]));
      check_val("in_ready", 32'(in_ready), 32'(adv_m));
      if (mv[STAGES-1]) begin
        check_val("sum", 32'(sum), 32'(mr[STAGES-1][WIDTH-1:0]));
        check_val("zero", 32'(zero), 32'(mr[STAGES-1][WIDTH]));
        check_val("overflow", 32'(overflow), 32'(mr[STAGES-1][WIDTH+1]));
        check_val("c_out", 32'(c_out), 32'(mr[STAGES-1][WIDTH+2]));
      end else if (chk_rst) begin
        check_val("rst_sum", 32'(sum), 32'd0);
        check_val("rst_c_out", 32'(c_out), 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        check_val("rst_zero", 32'(zero), 32'd0);
      end
      chk_rst = 1'b0;
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < STAGES; i++) mv[i] = 1'b0;
      chk_rst = 1'b1;
    end else if (adv_m) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        mr[i] = mr[i-1];
      end
      mv[0] = iv;
      mr[0] = ref_calc(ia, ib, ic, isb, sat_m);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, ADD, 1'b0, 1'b1);
  endtask

  function automatic logic [WIDTH-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(WIDTH-1){1'b1}}};
      3:       return {1'b1, {(WIDTH-1){1'b0}}};
      default: return WIDTH'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = ADD; out_ready = 1'b1;
`ifdef SATURATE_EN
    sat = 1'b0;
`endif
    chk_rst = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      mv[i] = 1'b0;
      mr[i] = '0;
    end

    step(1'b1, 1'b0, '0, '0, 1'b0, ADD, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, '0, 1'b0, ADD, 1'b0, 1'b1);

    // Corner beats, one at a time
    step(1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b0, ADD, 1'b0, 1'b1); idle(3);
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, ADD, 1'b0, 1'b1); idle(2);
    step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, ADD, 1'b0, 1'b1); idle(2);
    step(1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0, ADD, 1'b1, 1'b1); idle(2);
    step(1'b0, 1'b1, 16'h0005, 16'h0007, 1'b1, SUB, 1'b0, 1'b1); idle(2);
    step(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b0, SUB, 1'b0, 1'b1); idle(2);

    // Back-to-back beats with a three-cycle output stall
    step(1'b0, 1'b1, 16'd1, 16'd1, 1'b0, ADD, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd2, 16'd2, 1'b0, ADD, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd3, 16'd3, 1'b0, ADD, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'd3, 16'd3, 1'b0, ADD, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'd3, 16'd3, 1'b0, ADD, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'd3, 16'd3, 1'b0, ADD, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd4, 16'd4, 1'b0, ADD, 1'b0, 1'b1);
    idle(4);

    // Reset with two beats in flight
    step(1'b0, 1'b1, 16'h0011, 16'h0022, 1'b0, ADD, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h0033, 16'h0044, 1'b0, ADD, 1'b0, 1'b1);
    step(1'b1, 1'b1, 16'h0055, 16'h0066, 1'b0, ADD, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 16'h0010, 16'h0020, 1'b0, ADD, 1'b0, 1'b1);
    idle(3);

    // Randomized traffic with random back-pressure
    for (int n = 0; n < 500; n++) begin
      step(1'b0, ($urandom_range(0, 3) != 0), rnd_op(), rnd_op(),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    idle(STAGES + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
